formula_2_credit_buffer: RTL and testbench

- Sits directly downstream of the formula_2 pipelined datapath and wraps it with flow control.
- The datapath has fixed latency and no backpressure (arg_vld in, res_vld/res out). This block throttles argument issue with a credit counter so that every in-flight result is guaranteed a slot in a local result FIFO.
- Presents results to the consumer over a valid/ready handshake.
- Lets a stalling consumer sit behind a non-stallable pipeline without losing results.

---
 rtl/formula_2_credit_buffer_pkg.sv | 13 +
 rtl/formula_2_credit_buffer_if.sv | 23 ++
 rtl/formula_2_credit_buffer_result_fifo.sv | 53 +++++
 rtl/formula_2_credit_buffer.sv | 80 ++++++++
 tb/tb_formula_2_credit_buffer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/formula_2_credit_buffer_pkg.sv
// formula_2_credit_buffer_pkg: shared types, default sizes and pointer wrap helper
package formula_2_pkg;

    typedef logic [31:0] data_t;

    localparam int DEF_DEPTH   = 16;
    localparam int DEF_LATENCY = 8;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/formula_2_credit_buffer_if.sv
// formula_2_credit_buffer_if: upstream issue, datapath and downstream handshake signals
interface formula_2_credit_buffer_if #(
    parameter int WIDTH = 32
);
    logic             up_vld;
    logic             up_rdy;
    logic             pipe_arg_vld;
    logic             pipe_res_vld;
    logic [WIDTH-1:0] pipe_res;
    logic             down_vld;
    logic             down_rdy;
    logic [WIDTH-1:0] down_data;

    modport master (
        input  up_vld, pipe_res_vld, pipe_res, down_rdy,
        output up_rdy, pipe_arg_vld, down_vld, down_data
    );

    modport slave (
        output up_vld, pipe_res_vld, pipe_res, down_rdy,
        input  up_rdy, pipe_arg_vld, down_vld, down_data
    );
endinterface

// File: rtl/formula_2_credit_buffer_result_fifo.sv
// formula_2_result_fifo: result storage with zero-latency head, handles non-power-of-2 depth
module formula_2_result_fifo
    import formula_2_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       vld,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err_overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             wr_en;

    assign full  = count == CW'(DEPTH);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign vld   = count != '0;
    assign dout  = mem[rd_ptr];

    // Storage write at the tail.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    // Pointers, occupancy count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
            if (pop) rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
            if (wr_en && !pop) count <= count + 1'b1;
            else if (pop && !wr_en) count <= count - 1'b1;
            if (push && full && !pop) err_overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/formula_2_credit_buffer.sv
// formula_2_credit_buffer: credit-throttled issue into a fixed-latency datapath with a result FIFO
// Optional latency checker enabled by FORMULA_2_CREDIT_BUFFER_LATENCY_CHECK_EN.
module formula_2_credit_buffer
    import formula_2_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                       clk,
    input  logic                       rst,
    formula_2_credit_buffer_if.master  bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       err_unexpected,
    output logic                       err_overflow
`ifdef FORMULA_2_CREDIT_BUFFER_LATENCY_CHECK_EN
    ,
    output logic                       err_latency
`endif
);
    localparam int OW = $clog2(DEPTH + 1);

    logic [OW-1:0] count;
    logic [OW-1:0] in_flight;
    logic          issue;
    logic          pop;

    // Credits are only returned when the consumer takes a result, so every
    // in-flight result always has a reserved FIFO slot.
    assign bus.up_rdy       = occupancy != OW'(DEPTH);
    assign issue            = bus.up_vld & bus.up_rdy;
    assign bus.pipe_arg_vld = issue;
    assign pop              = bus.down_vld & bus.down_rdy;
    assign in_flight        = occupancy - count;

    formula_2_result_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (bus.pipe_res_vld),
        .pop         (pop),
        .din         (bus.pipe_res),
        .dout        (bus.down_data),
        .vld         (bus.down_vld),
        .count       (count),
        .err_overflow(err_overflow)
    );

    // Credit counter and sticky flag for results nobody asked for.
    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy      <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (issue && !pop) occupancy <= occupancy + 1'b1;
            else if (pop && !issue) occupancy <= occupancy - 1'b1;
            if (bus.pipe_res_vld && in_flight == '0) err_unexpected <= 1'b1;
        end
    end

`ifdef FORMULA_2_CREDIT_BUFFER_LATENCY_CHECK_EN
    logic [LATENCY-1:0] lat_sr;

    // Shadow of the issue stream delayed by the nominal latency; any
    // disagreement with the datapath's valid marks a latency fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_sr      <= '0;
            err_latency <= 1'b0;
        end else begin
            lat_sr <= LATENCY'({lat_sr, issue});
            if (lat_sr[LATENCY-1] != bus.pipe_res_vld) err_latency <= 1'b1;
        end
    end
`else
    localparam int unused_latency = LATENCY;
`endif
endmodule

// File: tb/tb_formula_2_credit_buffer.sv
// tb_formula_2_credit_buffer: scoreboard bench with a delay-line datapath model
module tb_formula_2_credit_buffer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    logic err_unexpected, err_overflow;
`ifdef FORMULA_2_CREDIT_BUFFER_LATENCY_CHECK_EN
    logic err_latency;
`endif

    formula_2_credit_buffer_if #(.WIDTH(WIDTH)) bus ();

    formula_2_credit_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .occupancy     (occupancy),
        .err_unexpected(err_unexpected),
        .err_overflow  (err_overflow)
`ifdef FORMULA_2_CREDIT_BUFFER_LATENCY_CHECK_EN
        ,
        .err_latency   (err_latency)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int seq = 0;
    int issues = 0;
    int pops = 0;
    int dly = 8;
    logic [15:0] pv = '0;
    logic [31:0] pd [16];
    logic inj_vld = 1'b0;
    logic [31:0] inj_data = '0;
    logic [31:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Datapath model: identity data (issue sequence number) delayed by dly cycles.
    assign bus.pipe_res_vld = pv[dly-1] | inj_vld;
    assign bus.pipe_res     = inj_vld ? inj_data : pd[dly-1];

    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
            exp_q.delete();
        end else begin
            pv <= {pv[14:0], bus.pipe_arg_vld};
            for (int i = 15; i > 0; i--) pd[i] <= pd[i-1];
            pd[0] <= seq;
            if (bus.pipe_arg_vld) begin
                exp_q.push_back(seq);
                seq <= seq + 1;
                issues <= issues + 1;
            end
        end
    end

    // Monitor: every accepted head must match the oldest issued argument.
    always @(negedge clk) begin
        if (!rst && bus.down_vld && bus.down_rdy) begin
            pops++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_order: got %0h with no result expected", bus.down_data);
            end else begin
                chk("pop_order", bus.down_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_occ(input int target, input string nm);
        int n = 0;
        while (32'(occupancy) != target && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(occupancy), target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, p0, n;
        logic ok_rdy;
        int max_occ;
        bus.up_vld = 1'b0;
        bus.down_rdy = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_down_vld", 32'(bus.down_vld), 0);
        chk("rst_up_rdy", 32'(bus.up_rdy), 1);
        chk("rst_err_unexp", 32'(err_unexpected), 0);
        chk("rst_err_ovf", 32'(err_overflow), 0);

        // Full rate for 100 cycles.
        tick();
        bus.up_vld = 1'b1;
        bus.down_rdy = 1'b1;
        p0 = pops;
        ok_rdy = 1'b1;
        max_occ = 0;
        repeat (100) begin
            @(negedge clk);
            if (!bus.up_rdy) ok_rdy = 1'b0;
            if (32'(occupancy) > max_occ) max_occ = 32'(occupancy);
        end
        tick();
        bus.up_vld = 1'b0;
        wait_occ(0, "fr_drain");
        chk("fr_up_rdy_held", 32'(ok_rdy), 1);
        chk("fr_occ_le_9", 32'(max_occ <= 9), 1);
        chk("fr_pop_count", pops - p0, 100);
        chk("fr_q_empty", exp_q.size(), 0);

        // Consumer stall: credits run out after DEPTH issues.
        tick();
        bus.down_rdy = 1'b0;
        bus.up_vld = 1'b1;
        i0 = issues;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.up_rdy && n < 100);
        chk("stall_up_rdy", 32'(bus.up_rdy), 0);
        chk("stall_issues", issues - i0, 16);
        chk("stall_occ", 32'(occupancy), 16);
        repeat (10) @(negedge clk);
        chk("stall_count", 32'(dut.u_fifo.count), 16);
        chk("stall_err_unexp", 32'(err_unexpected), 0);
        chk("stall_err_ovf", 32'(err_overflow), 0);

        // Push into a full FIFO with no pop: dropped and flagged.
        tick();
        inj_vld = 1'b1;
        inj_data = 32'hBADC0DE0;
        tick();
        inj_vld = 1'b0;
        @(negedge clk);
        chk("ovf_err", 32'(err_overflow), 1);
        chk("ovf_unexp", 32'(err_unexpected), 1);
        chk("ovf_count", 32'(dut.u_fifo.count), 16);

        // Release: first pop returns a credit, then issue+pop holds occupancy.
        tick();
        bus.down_rdy = 1'b1;
        @(negedge clk);
        chk("rel_rdy_before", 32'(bus.up_rdy), 0);
        @(negedge clk);
        chk("rel_rdy_after", 32'(bus.up_rdy), 1);
        chk("rel_occ_15", 32'(occupancy), 15);
        @(negedge clk);
        chk("rel_occ_const", 32'(occupancy), 15);
        tick();
        bus.up_vld = 1'b0;
        wait_occ(0, "rel_drain");
        chk("rel_q_empty", exp_q.size(), 0);

        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_err_ovf", 32'(err_overflow), 0);
        chk("rst2_err_unexp", 32'(err_unexpected), 0);

        // Spurious result with nothing in flight.
        tick();
        bus.down_rdy = 1'b0;
        inj_vld = 1'b1;
        inj_data = 32'hDEADBEEF;
        tick();
        inj_vld = 1'b0;
        @(negedge clk);
        chk("spur_err", 32'(err_unexpected), 1);
        chk("spur_down_vld", 32'(bus.down_vld), 1);
        chk("spur_data", bus.down_data, 32'hDEADBEEF);
        chk("spur_no_ovf", 32'(err_overflow), 0);
        repeat (3) @(negedge clk);
        chk("spur_sticky", 32'(err_unexpected), 1);

        // Reset mid-stream at occupancy 10.
        tick();
        bus.up_vld = 1'b1;
        wait_occ(10, "mid_occ_10");
        bus.up_vld = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_occ", 32'(occupancy), 0);
        chk("mid_down_vld", 32'(bus.down_vld), 0);
        chk("mid_up_rdy", 32'(bus.up_rdy), 1);
        chk("mid_err_unexp", 32'(err_unexpected), 0);
        chk("mid_err_ovf", 32'(err_overflow), 0);

`ifdef FORMULA_2_CREDIT_BUFFER_LATENCY_CHECK_EN
        chk("lat_rst", 32'(err_latency), 0);
        tick();
        dly = 7;
        bus.down_rdy = 1'b1;
        bus.up_vld = 1'b1;
        tick();
        bus.up_vld = 1'b0;
        repeat (12) @(negedge clk);
        chk("lat_short", 32'(err_latency), 1);
        tick();
        rst = 1'b1;
        dly = 8;
        tick();
        rst = 1'b0;
        repeat (3) begin
            bus.up_vld = 1'b1;
            tick();
        end
        bus.up_vld = 1'b0;
        repeat (14) @(negedge clk);
        chk("lat_nominal", 32'(err_latency), 0);
        chk("lat_q_empty", exp_q.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
